// File: rtl/seg_scan_if.sv
// Update channel for seg_scan_ctrl: display word, digit enables and decimal points
// offered with a valid/ready handshake.
interface seg_scan_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_value;
  logic [7:0]  upd_en;
  logic [7:0]  upd_dp;

  modport master (output upd_valid, upd_value, upd_en, upd_dp, input upd_ready);
  modport slave  (input upd_valid, upd_value, upd_en, upd_dp, output upd_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-shares one external hex-to-7-segment decoder across eight digits, latching
// each decoded pattern into its own register and rescanning on a free-running prescaler.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   upd,
  output logic [3:0]  dec_b,
  input  logic [7:0]  dec_h,
  output logic [63:0] seg,
  output logic        busy,
  output logic        scan_done
);
  localparam logic [31:0] PRESC_LAST = 32'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [31:0] presc_reg;
  logic [31:0] value_reg;
  logic [7:0]  en_reg, dp_reg;
  logic        tick, accept, ready_c;

  assign tick          = (presc_reg == PRESC_LAST);
  assign upd.upd_ready = ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= 32'd0;
    end else if (tick) begin
      presc_reg <= 32'd0;
    end else begin
      presc_reg <= presc_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= 32'd0;
      en_reg    <= 8'd0;
      dp_reg    <= 8'd0;
    end else if (accept) begin
      value_reg <= upd.upd_value;
      en_reg    <= upd.upd_en;
      dp_reg    <= upd.upd_dp;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    ready_c    = 1'b0;
    busy       = 1'b0;
    scan_done  = 1'b0;
    dec_b      = 4'd0;
    case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        // A pending update takes priority; the coincident tick is absorbed by its scan.
        if (upd.upd_valid) begin
          accept     = 1'b1;
          idx_next   = 3'd0;
          state_next = SCAN;
        end else if (tick) begin
          idx_next   = 3'd0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy     = 1'b1;
        dec_b    = value_reg[{idx_reg, 2'b00} +: 4];
        idx_next = 3'(idx_reg + 3'd1);
        if (idx_reg == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        scan_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Each digit owns a register that loads only in its SCAN slot, so others hold.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      logic [7:0] digit_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          digit_reg <= 8'hFF;
        end else if (state_reg == SCAN && idx_reg == 3'(gi)) begin
          digit_reg <= en_reg[gi] ? {dec_h[7:1], ~dp_reg[gi]} : 8'hFF;
        end
      end

      assign seg[8*gi +: 8] = digit_reg;
    end
  endgenerate
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and randomized checks of seg_scan_ctrl against a transaction-level model
// of the displayed patterns, with a real hex decoder wired to dec_b/dec_h.
module tb_seg_scan_ctrl;
  logic        clk;
  logic        rst_n;
  logic [3:0]  dec_b;
  logic [7:0]  dec_h;
  logic [63:0] seg;
  logic        busy;
  logic        scan_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;

  logic [31:0] m_val;
  logic [7:0]  m_en, m_dp;
  logic [63:0] exp_seg;

  seg_scan_if u_if ();

  seg_scan_ctrl #(.REFRESH_DIV(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd       (u_if),
    .dec_b     (dec_b),
    .dec_h     (dec_h),
    .seg       (seg),
    .busy      (busy),
    .scan_done (scan_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Segments a..g active-high, returned active-low with the DP bit dark.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;  default: s = 7'b1000111;
    endcase
    return {~s, 1'b1};
  endfunction

  function automatic logic [7:0] pat(input logic [3:0] n, input logic e, input logic d);
    logic [7:0] h;
    h = hex7(n);
    return e ? {h[7:1], ~d} : 8'hFF;
  endfunction

  always_comb dec_h = hex7(dec_b);

  always @(negedge clk) begin
    if (scan_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Mirrors the number of edges since reset release; tick cycles are cyc%16 == 15.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (u_if.upd_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk({tag, "_wait_ready"}, 64'(u_if.upd_ready), 64'd1);
  endtask

  task automatic accept(input logic [31:0] v, input logic [7:0] e, input logic [7:0] d);
    u_if.upd_value = v;
    u_if.upd_en    = e;
    u_if.upd_dp    = d;
    u_if.upd_valid = 1'b1;
    wait_ready("accept");
    step();
    u_if.upd_valid = 1'b0;
    m_val = v;
    m_en  = e;
    m_dp  = d;
  endtask

  // Entered one step after the edge that starts a scan; ends one step after DONE.
  task automatic run_scan(input string tag);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_dec_b"}, 64'(dec_b), 64'(m_val[4*k +: 4]));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_ready_low"}, 64'(u_if.upd_ready), 64'd0);
      step();
      exp_seg[8*k +: 8] = pat(m_val[4*k +: 4], m_en[k], m_dp[k]);
      chk({tag, "_seg"}, seg, exp_seg);
    end
    chk({tag, "_done_hi"}, 64'(scan_done), 64'd1);
    chk({tag, "_done_dec_b"}, 64'(dec_b), 64'd0);
    chk({tag, "_done_ready"}, 64'(u_if.upd_ready), 64'd0);
    step();
    chk({tag, "_done_lo"}, 64'(scan_done), 64'd0);
    chk({tag, "_ready_back"}, 64'(u_if.upd_ready), 64'd1);
    chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
    $display("scan %s value=%h en=%h dp=%h seg=%h", tag, m_val, m_en, m_dp, seg);
  endtask

  // From IDLE: stays idle until the next tick cycle, then rescans the snapshot.
  task automatic check_tick_rescan(input string tag);
    int n = 0;
    int bad = 0;
    while ((cyc % 16) != 15 && n < 40) begin
      if (u_if.upd_ready !== 1'b1) bad++;
      step();
      n++;
    end
    chk({tag, "_idle_until_tick"}, 64'(bad), 64'd0);
    chk({tag, "_tick_ready"}, 64'(u_if.upd_ready), 64'd1);
    step();
    chk({tag, "_tick_busy"}, 64'(busy), 64'd1);
    run_scan(tag);
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (!((cyc % 16) == ph && u_if.upd_ready === 1'b1) && n < 64) begin
      step();
      n++;
    end
    chk("phase_reached", 64'((cyc % 16) == ph), 64'd1);
  endtask

  initial begin
    int d0;
    logic [31:0] rv;
    logic [7:0]  re, rd;
    rst_n          = 1'b0;
    u_if.upd_valid = 1'b0;
    u_if.upd_value = 32'd0;
    u_if.upd_en    = 8'd0;
    u_if.upd_dp    = 8'd0;
    m_val = 32'd0; m_en = 8'd0; m_dp = 8'd0;
    exp_seg = {64{1'b1}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_ready", 64'(u_if.upd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dec_b", 64'(dec_b), 64'd0);
    chk("rst_done", 64'(scan_done), 64'd0);
    rst_n = 1'b1;

    accept(32'h0123_4567, 8'hFF, 8'h00);
    run_scan("basic");
    chk("basic_d0", 64'(seg[7:0]), 64'h1F);
    chk("basic_d1", 64'(seg[15:8]), 64'h41);
    chk("basic_d6", 64'(seg[55:48]), 64'h9F);
    chk("basic_d7", 64'(seg[63:56]), 64'h03);

    accept(32'hFFFF_FFFF, 8'h0F, 8'h01);
    run_scan("mask_dp");
    chk("mask_dp_seg", seg, 64'hFFFF_FFFF_7171_7170);
    check_tick_rescan("refresh1");
    check_tick_rescan("refresh2");

    // Backpressure: hold an update while a scan is running.
    accept($urandom, 8'($urandom), 8'($urandom));
    u_if.upd_value = 32'h8888_8888;
    u_if.upd_en    = 8'hFF;
    u_if.upd_dp    = 8'h00;
    u_if.upd_valid = 1'b1;
    run_scan("bp_first");
    step();
    u_if.upd_valid = 1'b0;
    m_val = 32'h8888_8888; m_en = 8'hFF; m_dp = 8'h00;
    run_scan("bp_held");
    chk("bp_seg", seg, 64'h0101_0101_0101_0101);

    // Update coincident with a tick: one scan only, next scan at the following tick.
    wait_phase(15);
    accept($urandom, 8'($urandom), 8'($urandom));
    run_scan("tick_same");
    d0 = done_cnt;
    repeat (6) step();
    chk("tick_same_no_extra", 64'(done_cnt), 64'(d0));
    chk("tick_same_idle", 64'(u_if.upd_ready), 64'd1);
    check_tick_rescan("tick_same_next");

    // Tick falling inside SCAN is dropped.
    wait_phase(10);
    accept($urandom, 8'($urandom), 8'($urandom));
    run_scan("tick_in_scan");
    check_tick_rescan("tick_in_scan_next");

    for (int i = 0; i < 6; i++) begin
      rv = $urandom; re = 8'($urandom); rd = 8'($urandom);
      accept(rv, re, rd);
      run_scan("random");
    end

    // Reset in the middle of a scan, at idx 3.
    accept($urandom, 8'($urandom) | 8'h0F, 8'($urandom));
    repeat (3) step();
    chk("mid_idx3_dec_b", 64'(dec_b), 64'(m_val[15:12]));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mid_rst_ready", 64'(u_if.upd_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dec_b", 64'(dec_b), 64'd0);
    m_val = 32'd0; m_en = 8'd0; m_dp = 8'd0;
    exp_seg = {64{1'b1}};
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_tick_rescan("post_rst");
    chk("post_rst_seg", seg, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
